// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host-side master.
// Holds the FSM state encoding, bus widths and the timeout counter width helper.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int ctr_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Acknowledge timeout counter: counts bus cycles without ack and flags the last permitted one.
// expired_o is high during the BUS cycle whose end brings the count to TIMEOUT_CYCLES.
module wb_timeout_ctr
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TOP)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master bridging a valid/ready host request
// port to the bus, with an acknowledge timeout that returns an error response.
//
// state | meaning
// IDLE  | ready for a host request, bus quiet
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held until the host takes it
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [WB_ADR_W-1:0] req_adr_i,
  input  logic [WB_DAT_W-1:0] req_dat_i,
  input  logic [WB_SEL_W-1:0] req_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                busy_o
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept;
  logic                  in_bus;
  logic                  expired;

  // Ready is masked during reset so nothing is accepted on a resetting edge.
  assign req_ready_o = (state_q == IDLE) && wb_rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign in_bus      = (state_q == BUS);

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clear_i  (accept),
    .en_i     (in_bus && !wbm_ack_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUS;
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
        end
      end
      BUS: begin
        // Ack is checked first so a last-cycle ack still completes cleanly.
        if (wbm_ack_i) begin
          state_d   = RESP;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
        end else if (expired) begin
          state_d   = RESP;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign wbm_cyc_o   = in_bus;
  assign wbm_stb_o   = in_bus;
  assign wbm_we_o    = in_bus && we_q;
  assign wbm_sel_o   = in_bus ? sel_q : '0;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: two instances (timeout 4 and 3) share
// stimulus, with requests and response-ready steered to the selected one.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, ack = 1'b0;
  logic [31:0] req_adr = '0, req_dat = '0, slv_dat = 32'h5555_AAAA;
  logic [3:0]  req_sel = '0;
  int          d = 0;

  logic [1:0]       rv, rr, req_ready, rsp_valid, rsp_err, cyc, stb, we, busy;
  logic [1:0][31:0] rsp_dat, adr_o, dat_o;
  logic [1:0][3:0]  sel_o;

  assign rv = {req_valid && (d == 1), req_valid && (d == 0)};
  assign rr = {rsp_ready && (d == 1), rsp_ready && (d == 0)};

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid_i(rv[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rr[0]), .rsp_dat_o(rsp_dat[0]),
    .rsp_err_o(rsp_err[0]), .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_we_o(we[0]),
    .wbm_adr_o(adr_o[0]), .wbm_dat_o(dat_o[0]), .wbm_sel_o(sel_o[0]),
    .wbm_dat_i(slv_dat), .wbm_ack_i(ack), .busy_o(busy[0])
  );

  wb_host_master #(.TIMEOUT_CYCLES(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid_i(rv[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rr[1]), .rsp_dat_o(rsp_dat[1]),
    .rsp_err_o(rsp_err[1]), .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_we_o(we[1]),
    .wbm_adr_o(adr_o[1]), .wbm_dat_o(dat_o[1]), .wbm_sel_o(sel_o[1]),
    .wbm_dat_i(slv_dat), .wbm_ack_i(ack), .busy_o(busy[1])
  );

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          ack_at;   // BUS cycle carrying ack, 0 = never
    logic [31:0] rdat;
    int          hold;     // cycles rsp_ready stays low in RESP
    int          exp_bus;  // BUS cycles with cyc high
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  vec_t vecs[7];
  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    bit   done;
    rsp_t e;
    d = v.d;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_dat = v.wdat; req_sel = v.sel;
    chk("req_ready idle", {31'd0, req_ready[d]}, 32'd1);
    sb.push_back('{v.exp_dat, v.exp_err});
    @(negedge clk);
    req_valid = 1'b0; req_adr = 32'hFFFF_FFFF; req_dat = 32'hFFFF_FFFF; req_sel = 4'h0; req_we = ~v.we;
    n = 0;
    done = 1'b0;
    while (!done) begin
      n++;
      chk("bus cyc", {31'd0, cyc[d]}, 32'd1);
      chk("bus stb", {31'd0, stb[d]}, 32'd1);
      chk("bus we", {31'd0, we[d]}, {31'd0, v.we});
      chk("bus adr", adr_o[d], v.adr);
      chk("bus dat", dat_o[d], v.wdat);
      chk("bus sel", {28'd0, sel_o[d]}, {28'd0, v.sel});
      chk("bus rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("bus req_ready", {31'd0, req_ready[d]}, 32'd0);
      if (n == v.ack_at) begin
        ack = 1'b1;
        slv_dat = v.rdat;
      end
      @(negedge clk);
      ack = 1'b0;
      slv_dat = 32'h5555_AAAA;
      if (n == v.ack_at || cyc[d] == 1'b0 || n >= 20) done = 1'b1;
    end
    chk("bus cycles", n, v.exp_bus);
    chk("resp cyc", {31'd0, cyc[d]}, 32'd0);
    chk("resp stb", {31'd0, stb[d]}, 32'd0);
    chk("resp we", {31'd0, we[d]}, 32'd0);
    chk("resp busy", {31'd0, busy[d]}, 32'd1);
    for (int i = 0; i < v.hold; i++) begin
      chk("hold rsp_valid", {31'd0, rsp_valid[d]}, 32'd1);
      chk("hold rsp_dat", rsp_dat[d], v.exp_dat);
      chk("hold req_ready", {31'd0, req_ready[d]}, 32'd0);
      @(negedge clk);
    end
    chk("resp rsp_valid", {31'd0, rsp_valid[d]}, 32'd1);
    chk("resp req_ready", {31'd0, req_ready[d]}, 32'd0);
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_dat", rsp_dat[d], e.dat);
      chk("rsp_err", {31'd0, rsp_err[d]}, {31'd0, e.err});
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
    chk("done busy", {31'd0, busy[d]}, 32'd0);
    chk("done req_ready", {31'd0, req_ready[d]}, 32'd1);
    chk("done sel", {28'd0, sel_o[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          d  we    adr           wdat          sel   ack rdat          hold bus exp_dat       err
    vecs[0] = '{0, 1'b0, 32'h3000_0004, 32'h0,        4'hF, 3, 32'h4049_0FDB, 0, 3, 32'h4049_0FDB, 1'b0};
    vecs[1] = '{0, 1'b1, 32'h3000_0000, 32'h0000_3F80, 4'h3, 1, 32'hDEAD_BEEF, 0, 1, 32'h0,         1'b0};
    vecs[2] = '{0, 1'b0, 32'h3000_0010, 32'h0,        4'hF, 0, 32'h0,         0, 4, 32'h0,         1'b1};
    vecs[3] = '{0, 1'b0, 32'h3000_0020, 32'h0,        4'hC, 1, 32'h1234_5678, 5, 1, 32'h1234_5678, 1'b0};
    vecs[4] = '{1, 1'b0, 32'h3000_0030, 32'h0,        4'h1, 3, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF, 0, 32'h0,         2, 3, 32'h0,         1'b1};
    vecs[6] = '{0, 1'b0, 32'h3000_0050, 32'h0,        4'h6, 4, 32'hA5A5_5A5A, 0, 4, 32'hA5A5_5A5A, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      d = k;
      chk("reset cyc", {31'd0, cyc[k]}, 32'd0);
      chk("reset stb", {31'd0, stb[k]}, 32'd0);
      chk("reset we", {31'd0, we[k]}, 32'd0);
      chk("reset adr", adr_o[k], 32'd0);
      chk("reset dat", dat_o[k], 32'd0);
      chk("reset sel", {28'd0, sel_o[k]}, 32'd0);
      chk("reset rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      chk("reset rsp_dat", rsp_dat[k], 32'd0);
      chk("reset rsp_err", {31'd0, rsp_err[k]}, 32'd0);
      chk("reset busy", {31'd0, busy[k]}, 32'd0);
      chk("reset req_ready", {31'd0, req_ready[k]}, 32'd1);
    end

    d = 0;
    ack = 1'b1;
    slv_dat = 32'hFFFF_FFFF;
    @(negedge clk);
    ack = 1'b0;
    slv_dat = 32'h5555_AAAA;
    chk("idle ack busy", {31'd0, busy[0]}, 32'd0);
    chk("idle ack cyc", {31'd0, cyc[0]}, 32'd0);
    chk("idle ack rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("idle ack rsp_dat", rsp_dat[0], 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    d = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0008; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst bus cyc1", {31'd0, cyc[0]}, 32'd1);
    @(negedge clk);
    chk("rst bus cyc2", {31'd0, cyc[0]}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst cyc", {31'd0, cyc[0]}, 32'd0);
    chk("rst stb", {31'd0, stb[0]}, 32'd0);
    chk("rst busy", {31'd0, busy[0]}, 32'd0);
    chk("rst adr", adr_o[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      ack = (i == 0);
      @(negedge clk);
      ack = 1'b0;
      chk("rst no rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    end
    run_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 The block SHALL have one clock, wb_clk_i, and reset wb_rst_i, which is synchronous and active-low (asserted when 0).
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, maximum number of wb_clk_i cycles the block waits for acknowledge (legal range 1..65535).
REQ-003 wb_clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  synchronous active-low reset.
REQ-005 req_valid_i  input  1  a host request is present.
REQ-006 req_ready_o  output  1  the block accepts a request this cycle.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_adr_i  input  32  byte address.
REQ-009 req_dat_i  input  32  write data.
REQ-010 req_sel_i  input  4  byte lane select.
REQ-011 rsp_valid_o  output  1  a response is present.
REQ-012 rsp_ready_i  input  1  the host consumes the response.
REQ-013 rsp_dat_o  output  32  read data; 0 for writes and timeouts.
REQ-014 rsp_err_o  output  1  the transaction timed out.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-016 wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4  Wishbone address, write data and byte select.
REQ-017 wbm_dat_i  input  32; wbm_ack_i  input  1  slave read data and acknowledge.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-020 In IDLE, req_ready_o SHALL be 1; in BUS and RESP it SHALL be 0.
REQ-021 IDLE->BUS: on req_valid_i&&req_ready_o, the block SHALL register we, adr, dat and sel, and drive wbm_cyc_o=wbm_stb_o=1 from the next cycle.
REQ-022 In BUS, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o SHALL be held stable until the transaction ends.
REQ-023 BUS->RESP on wbm_ack_i=1: on that edge the block SHALL drop cyc/stb, capture wbm_dat_i into rsp_dat_o (reads only; 0 for writes) and clear rsp_err_o.
REQ-024 A timeout counter SHALL clear on entry to BUS and increment once per BUS cycle without ack.
REQ-025 When the counter reaches TIMEOUT_CYCLES without ack, the block SHALL go BUS->RESP, drop cyc/stb, set rsp_err_o=1 and set rsp_dat_o=0.
REQ-026 If ack and the timeout condition occur in the same cycle, ack SHALL win and rsp_err_o SHALL be 0.
REQ-027 In RESP, rsp_valid_o SHALL be 1 and rsp_dat_o/rsp_err_o SHALL be stable; RESP->IDLE on rsp_ready_i=1.
REQ-028 Latency: request accepted at cycle 0, cyc/stb high at cycle 1, ack sampled at cycle k>=1, rsp_valid_o high at cycle k+1.
REQ-029 The block SHALL give a maximum throughput of one transaction per 3 cycles; it SHALL NOT accept a new request in the RESP cycle.
REQ-030 wbm_ack_i SHALL be ignored outside BUS.
REQ-031 wbm_stb_o SHALL never be high without wbm_cyc_o.
REQ-032 When idle, wbm_we_o and wbm_sel_o SHALL be 0.

Reset
REQ-033 While wb_rst_i=0 at a clock edge, the block SHALL enter IDLE.
REQ-034 Reset values: wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_adr_o=wbm_dat_o=0; wbm_sel_o=0; rsp_valid_o=0; rsp_dat_o=0; rsp_err_o=0; busy_o=0; req_ready_o=1 after release; timeout counter=0.
REQ-035 Reset mid-transaction SHALL drop cyc/stb at that edge and discard any pending response; no rsp_valid_o SHALL follow.

Structure
REQ-036 A shared package wb_host_pkg SHALL hold the state enum (IDLE/BUS/RESP), the WB_ADR_W=32, WB_DAT_W=32 and WB_SEL_W=4 constants, and the counter width function $clog2(TIMEOUT_CYCLES+1).
REQ-037 The timeout counter SHALL be a sub-module named wb_timeout_ctr, with clear, enable and expired ports.

Verification
REQ-038 Read: req adr=0x3000_0004, sel=0xF; slave acks on cycle 3 with 0x4049_0FDB -> rsp_valid_o at cycle 4, rsp_dat_o=0x4049_0FDB, rsp_err_o=0.
REQ-039 Write: adr=0x3000_0000, dat=0x0000_3F80, sel=0x3, ack after 1 cycle -> wbm_we_o=1 and bus fields stable until ack; rsp_dat_o=0, rsp_err_o=0.
REQ-040 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc/stb drop after 4 BUS cycles; rsp_err_o=1, rsp_dat_o=0.
REQ-041 Back-pressure: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o held with stable data; req_ready_o=0 throughout; accepted on release.
REQ-042 Reset in BUS at cycle 2 -> cyc/stb=0 at the next edge, no response issued, and a subsequent read completes normally.
REQ-043 Ack coincident with timeout cycle (TIMEOUT_CYCLES=3, ack on BUS cycle 3) -> rsp_err_o=0 with captured data; a spurious ack in IDLE -> no state change.
